alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Parametrised, multi-beat successor to the 8-bit ALU control block. It loads DATA_WIDTH-bit operands A and B over a narrow BUS_WIDTH data bus, and executes one of eight operations slice-serially, one BUS_WIDTH slice per cycle with carry chained between slices. Results and a status word are read back over the same narrow bus. It sits between the TinyTapeout pin mux and the datapath, and replaces the single-beat, state-per-control-code scheme with a command/valid handshake and busy/done signalling.

Parameters:
- DATA_WIDTH, 16, operand and result width; must be an integer multiple of BUS_WIDTH.
- BUS_WIDTH, 8, data_in/data_out width; must be >= 4.
- BEATS (localparam), DATA_WIDTH/BUS_WIDTH, beats per operand, beats per result, and EXEC cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command/data beat strobe; accepted only when busy=0.
- cmd  in  2  00 LOAD_A, 01 LOAD_B, 10 EXEC, 11 READ.
- op  in  3  operation; sampled with EXEC.
- carry_in  in  1  carry/borrow/shift-fill; sampled with EXEC.
- data_in  in  BUS_WIDTH  operand slice; sampled on LOAD beats.
- data_out  out  BUS_WIDTH  registered read-back slice.
- out_valid  out  1  one-cycle pulse; data_out is new this cycle.
- busy  out  1  high while a LOAD sequence (after its first beat) or an EXEC is in progress.
- done  out  1  one-cycle pulse when EXEC results are committed.

Behaviour:
- Reset (rst_n=0 at an edge) clears: FSM to IDLE; A, B, result and flags to 0; load/read pointers to 0; data_out=0; out_valid=0; busy=0; done=0. Reset has priority over everything, including a mid-LOAD or mid-EXEC operation, whose partial state is discarded.
- FSM states are IDLE, LOAD, EXEC.
- IDLE, LOAD_A/LOAD_B beat:
  - data_in is written to slice 0 of the selected register (slices are LSB first).
  - If BEATS>1, go to LOAD with ptr=1 and busy=1.
- LOAD state:
  - Each cmd_valid beat writes data_in to slice ptr of the register selected at the first beat; cmd is ignored.
  - After slice BEATS-1 is written, return to IDLE and set busy=0.
  - The register is only partially updated until the sequence completes.
- IDLE, EXEC beat (cycle 0):
  - Latch op and carry_in. busy=1 in cycles 1..BEATS; slice k is computed in cycle k+1, and the inter-slice carry is held in a register.
  - In cycle BEATS+1 the result and flags commit, done=1, busy=0, and the read pointer resets to 0.
  - Result registers keep their previous values until commit.
- Ops (a, b are unsigned DATA_WIDTH; c = carry_in):
  - 000 ADD: a+b+c. C = carry out.
  - 001 SUB: a-b-c. C = borrow, i.e. 1 iff a < b+c unsigned.
  - 010 AND, 011 OR, 100 XOR. C = 0.
  - 101 NOT_A. C = 0.
  - 110 SHL1: {a[DW-2:0], c}. C = a[DW-1].
  - 111 PASS_B. C = 0.
  - All results are truncated to DATA_WIDTH.
- Flags:
  - Z = result==0.
  - N = result[DW-1].
  - V = signed overflow for ADD/SUB; 0 for all other ops.
- IDLE, READ beat:
  - If rptr<BEATS, data_out = result slice rptr on the next cycle.
  - If rptr==BEATS, data_out = status word, zero-extended: {0.., V, N, Z, C} (bit0=C, bit1=Z, bit2=N, bit3=V).
  - out_valid pulses in the same cycle data_out updates. rptr wraps to 0 after the status beat.
  - data_out holds its value between reads.
- Any cmd_valid while busy=1 and not in LOAD is dropped silently, with no state change.
- Back-to-back beats: one beat is accepted per cycle, and IDLE accepts a new command in the cycle after busy falls.
- EXEC issued before any load uses current A/B (0 after reset).

Test Plan:
- DW=16, BW=8: LOAD_A 0x34,0x12; LOAD_B 0xFF,0x00; EXEC ADD c=0; 3x READ -> 0x33, 0x13, status 0x00. busy high exactly 2 cycles; done pulses once, 3 cycles after EXEC accept.
- A=0x0001, B=0x0002, SUB c=0 -> reads 0xFF, 0xFF, status 0x05 (borrow, N). A=0x7FFF, B=0x0001, ADD -> 0x00, 0x80, status 0x0C (N, V).
- A=0xFFFF, B=0x0001, ADD -> 0x00, 0x00, status 0x03 (C, Z). A=0x8001, SHL1 c=1 -> 0x03, 0x00, status 0x01.
- cmd_valid LOAD_A 0xAA asserted during EXEC busy -> ignored; A unchanged; the EXEC result matches the pre-issue A.
- rst_n=0 for one edge in the middle of EXEC and in the middle of a LOAD_B sequence -> outputs 0, FSM IDLE, next READ returns 0x00; a fresh 2-beat load then works normally.
- 4th READ after the status beat wraps and returns result slice 0 again. With DW=8, BW=8, LOAD takes 1 beat (busy stays 0) and EXEC busy lasts 1 cycle.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - command/data handshake bundle between pin mux and alu_sequencer
interface alu_sequencer_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 cmd_valid;
  logic [1:0]           cmd;
  logic [2:0]           op;
  logic                 carry_in;
  logic [BUS_WIDTH-1:0] data_in;
  logic [BUS_WIDTH-1:0] data_out;
  logic                 out_valid;
  logic                 busy;
  logic                 done;

  modport master (
    output cmd_valid, cmd, op, carry_in, data_in,
    input  data_out, out_valid, busy, done
  );

  modport slave (
    input  cmd_valid, cmd, op, carry_in, data_in,
    output data_out, out_valid, busy, done
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-beat operand loader and slice-serial ALU with narrow read-back
module alu_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int BUS_WIDTH  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  bus
);
  localparam int BEATS = DATA_WIDTH / BUS_WIDTH;
  localparam int PW    = $clog2(BEATS + 1);
  localparam logic [PW-1:0] LAST = PW'(BEATS - 1);
  localparam logic [PW-1:0] STAT = PW'(BEATS);

  localparam logic [1:0] CMD_LOAD_A = 2'b00;
  localparam logic [1:0] CMD_LOAD_B = 2'b01;
  localparam logic [1:0] CMD_EXEC   = 2'b10;
  localparam logic [1:0] CMD_READ   = 2'b11;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOTA = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {IDLE, LOAD, EXEC} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [3:0]            flags_q, flags_d;
  logic [PW-1:0]         lptr_q, lptr_d, cnt_q, cnt_d, rptr_q, rptr_d;
  logic                  sel_b_q, sel_b_d;
  logic [2:0]            op_q, op_d;
  logic                  cy_q, cy_d;
  logic [BUS_WIDTH-1:0]  data_out_q, data_out_d;
  logic                  out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;

  logic [BUS_WIDTH-1:0]  as, bs, res_s;
  logic [BUS_WIDTH:0]    sum;
  logic                  co;

  // SUB runs as a + ~b + ~c so one adder and one carry register serve both
  always_comb begin
    as    = a_q[cnt_q*BUS_WIDTH +: BUS_WIDTH];
    bs    = b_q[cnt_q*BUS_WIDTH +: BUS_WIDTH];
    sum   = {1'b0, as} + {1'b0, (op_q == OP_SUB) ? ~bs : bs} + {{BUS_WIDTH{1'b0}}, cy_q};
    res_s = sum[BUS_WIDTH-1:0];
    co    = sum[BUS_WIDTH];
    case (op_q)
      OP_AND:  begin res_s = as & bs; co = 1'b0; end
      OP_OR:   begin res_s = as | bs; co = 1'b0; end
      OP_XOR:  begin res_s = as ^ bs; co = 1'b0; end
      OP_NOTA: begin res_s = ~as;     co = 1'b0; end
      OP_SHL1: begin res_s = {as[BUS_WIDTH-2:0], cy_q}; co = as[BUS_WIDTH-1]; end
      OP_PASS: begin res_s = bs;      co = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    flags_d     = flags_q;
    lptr_d      = lptr_q;
    cnt_d       = cnt_q;
    rptr_d      = rptr_q;
    sel_b_d     = sel_b_q;
    op_d        = op_q;
    cy_d        = cy_q;
    data_out_d  = data_out_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        case (bus.cmd)
          CMD_LOAD_A, CMD_LOAD_B: begin
            sel_b_d = bus.cmd[0];
            if (bus.cmd[0]) b_d[BUS_WIDTH-1:0] = bus.data_in;
            else            a_d[BUS_WIDTH-1:0] = bus.data_in;
            if (BEATS > 1) begin
              state_d = LOAD;
              lptr_d  = PW'(1);
              busy_d  = 1'b1;
            end
          end
          CMD_EXEC: begin
            op_d    = bus.op;
            cy_d    = (bus.op == OP_SUB) ? ~bus.carry_in : bus.carry_in;
            cnt_d   = '0;
            state_d = EXEC;
            busy_d  = 1'b1;
          end
          CMD_READ: begin
            out_valid_d = 1'b1;
            if (rptr_q == STAT) begin
              data_out_d      = '0;
              data_out_d[3:0] = flags_q;
              rptr_d          = '0;
            end else begin
              data_out_d = result_q[rptr_q*BUS_WIDTH +: BUS_WIDTH];
              rptr_d     = rptr_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
      LOAD: if (bus.cmd_valid) begin
        if (sel_b_q) b_d[lptr_q*BUS_WIDTH +: BUS_WIDTH] = bus.data_in;
        else         a_d[lptr_q*BUS_WIDTH +: BUS_WIDTH] = bus.data_in;
        if (lptr_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          lptr_d = lptr_q + 1'b1;
        end
      end
      EXEC: begin
        acc_d[cnt_q*BUS_WIDTH +: BUS_WIDTH] = res_s;
        cy_d = co;
        if (cnt_q == LAST) begin
          result_d   = acc_d;
          flags_d[1] = (acc_d == '0);
          flags_d[2] = acc_d[DATA_WIDTH-1];
          case (op_q)
            OP_ADD:  flags_d[0] = co;
            OP_SUB:  flags_d[0] = ~co;
            OP_SHL1: flags_d[0] = co;
            default: flags_d[0] = 1'b0;
          endcase
          case (op_q)
            OP_ADD:  flags_d[3] = (a_q[DATA_WIDTH-1] == b_q[DATA_WIDTH-1]) &&
                                  (acc_d[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
            OP_SUB:  flags_d[3] = (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]) &&
                                  (acc_d[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
            default: flags_d[3] = 1'b0;
          endcase
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rptr_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      lptr_q      <= '0;
      cnt_q       <= '0;
      rptr_q      <= '0;
      sel_b_q     <= 1'b0;
      op_q        <= '0;
      cy_q        <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      lptr_q      <= lptr_d;
      cnt_q       <= cnt_d;
      rptr_q      <= rptr_d;
      sel_b_q     <= sel_b_d;
      op_q        <= op_d;
      cy_q        <= cy_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed bench with read-back scoreboard for alu_sequencer
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.BUS_WIDTH(8)) i16 ();
  alu_sequencer_if #(.BUS_WIDTH(8)) i8 ();

  alu_sequencer #(.DATA_WIDTH(16), .BUS_WIDTH(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));
  alu_sequencer #(.DATA_WIDTH(8),  .BUS_WIDTH(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0]  sb[$];
  logic [15:0] m_a, m_b, m_res;
  logic [3:0]  m_stat;
  int          m_rptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] alu_ref(input logic [2:0] o, input logic [15:0] a,
                                           input logic [15:0] b, input logic c);
    logic [16:0] s;
    logic [15:0] r;
    logic        cf, vf;
    cf = 1'b0;
    vf = 1'b0;
    case (o)
      3'b000: begin
        s  = {1'b0, a} + {1'b0, b} + {16'd0, c};
        r  = s[15:0];
        cf = s[16];
        vf = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'b001: begin
        r  = a - b - {15'd0, c};
        cf = ({1'b0, a} < ({1'b0, b} + {16'd0, c}));
        vf = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = ~a;
      3'b110: begin r = {a[14:0], c}; cf = a[15]; end
      default: r = b;
    endcase
    return {vf, r[15], (r == 16'd0), cf, r};
  endfunction

  always @(negedge clk) begin
    if (i16.out_valid === 1'b1) begin
      check("unexpected_out_valid", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("read_data", 32'(i16.data_out), 32'(sb.pop_front()));
    end
  end

  task automatic beat16(input logic [1:0] c, input logic [7:0] d, input logic [2:0] o, input logic ci);
    i16.cmd_valid = 1'b1;
    i16.cmd = c; i16.data_in = d; i16.op = o; i16.carry_in = ci;
    @(negedge clk);
    i16.cmd_valid = 1'b0;
  endtask

  task automatic beat8(input logic [1:0] c, input logic [7:0] d, input logic [2:0] o, input logic ci);
    i8.cmd_valid = 1'b1;
    i8.cmd = c; i8.data_in = d; i8.op = o; i8.carry_in = ci;
    @(negedge clk);
    i8.cmd_valid = 1'b0;
  endtask

  task automatic load16(input logic sel_b, input logic [15:0] v);
    beat16({1'b0, sel_b}, v[7:0], 3'd0, 1'b0);
    check("load_busy_mid", 32'(i16.busy), 32'd1);
    beat16(2'b10, v[15:8], 3'd0, 1'b0);
    check("load_busy_end", 32'(i16.busy), 32'd0);
    if (sel_b) m_b = v; else m_a = v;
  endtask

  task automatic exec16(input logic [2:0] o, input logic ci);
    int busy_cnt = 0, done_cnt = 0, done_at = 0;
    beat16(2'b10, 8'h00, o, ci);
    for (int i = 1; i <= 6; i++) begin
      if (i16.busy === 1'b1) busy_cnt++;
      if (i16.done === 1'b1) begin done_cnt++; if (done_at == 0) done_at = i; end
      @(negedge clk);
    end
    check("exec_busy_cycles", busy_cnt, 2);
    check("exec_done_cycle", done_at, 3);
    check("exec_done_pulses", done_cnt, 1);
    {m_stat, m_res} = alu_ref(o, m_a, m_b, ci);
    m_rptr = 0;
  endtask

  task automatic read16();
    sb.push_back(m_rptr < 2 ? m_res[m_rptr*8 +: 8] : {4'b0, m_stat});
    m_rptr = (m_rptr == 2) ? 0 : m_rptr + 1;
    beat16(2'b11, 8'h00, 3'd0, 1'b0);
  endtask

  task automatic read3();
    for (int i = 0; i < 3; i++) read16();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_a = '0; m_b = '0; m_res = '0; m_stat = '0; m_rptr = 0;
  endtask

  task automatic check_idle16(input string tag);
    check({tag, "_busy"}, 32'(i16.busy), 32'd0);
    check({tag, "_done"}, 32'(i16.done), 32'd0);
    check({tag, "_out_valid"}, 32'(i16.out_valid), 32'd0);
    check({tag, "_data_out"}, 32'(i16.data_out), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int busy_cnt, done_at;
    i16.cmd_valid = 1'b0; i16.cmd = '0; i16.op = '0; i16.carry_in = 1'b0; i16.data_in = '0;
    i8.cmd_valid  = 1'b0; i8.cmd  = '0; i8.op  = '0; i8.carry_in  = 1'b0; i8.data_in  = '0;
    m_a = '0; m_b = '0; m_res = '0; m_stat = '0; m_rptr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle16("reset");
    read3();

    load16(1'b0, 16'h1234); load16(1'b1, 16'h00FF); exec16(3'b000, 1'b0); read3();
    load16(1'b0, 16'h0001); load16(1'b1, 16'h0002); exec16(3'b001, 1'b0); read3();
    load16(1'b0, 16'h7FFF); load16(1'b1, 16'h0001); exec16(3'b000, 1'b0); read3();
    load16(1'b0, 16'hFFFF); load16(1'b1, 16'h0001); exec16(3'b000, 1'b0); read3();
    load16(1'b0, 16'h8001); exec16(3'b110, 1'b1); read3(); read16();

    // LOAD_A while EXEC is busy must be dropped
    load16(1'b0, 16'h0F0F); load16(1'b1, 16'h0101);
    beat16(2'b10, 8'h00, 3'b000, 1'b0);
    beat16(2'b00, 8'hAA, 3'b000, 1'b0);
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      if (i16.done === 1'b1) got = 1; else @(negedge clk);
    end
    check("drop_done_seen", got, 1);
    {m_stat, m_res} = alu_ref(3'b000, m_a, m_b, 1'b0);
    m_rptr = 0;
    read3();
    exec16(3'b101, 1'b0); read3();

    beat16(2'b10, 8'h00, 3'b000, 1'b1);
    check("mid_exec_busy", 32'(i16.busy), 32'd1);
    pulse_reset();
    check_idle16("rst_exec");
    read16();

    beat16(2'b01, 8'h55, 3'd0, 1'b0);
    check("mid_load_busy", 32'(i16.busy), 32'd1);
    pulse_reset();
    check_idle16("rst_load");
    read16();
    m_rptr = 1; read16(); read16();
    exec16(3'b000, 1'b1); read3();

    load16(1'b0, 16'h9C3A); load16(1'b1, 16'h65C5);
    for (int o = 0; o < 8; o++) begin
      exec16(3'(o), 1'b1);
      read3();
    end

    beat8(2'b00, 8'hF0, 3'd0, 1'b0);
    check("dw8_load_a_busy", 32'(i8.busy), 32'd0);
    beat8(2'b01, 8'h20, 3'd0, 1'b0);
    check("dw8_load_b_busy", 32'(i8.busy), 32'd0);
    beat8(2'b10, 8'h00, 3'b000, 1'b0);
    busy_cnt = 0; done_at = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i8.busy === 1'b1) busy_cnt++;
      if (i8.done === 1'b1 && done_at == 0) done_at = i;
      @(negedge clk);
    end
    check("dw8_exec_busy_cycles", busy_cnt, 1);
    check("dw8_exec_done_cycle", done_at, 2);
    beat8(2'b11, 8'h00, 3'd0, 1'b0);
    check("dw8_read0_valid", 32'(i8.out_valid), 32'd1);
    check("dw8_read0_data", 32'(i8.data_out), 32'h10);
    beat8(2'b11, 8'h00, 3'd0, 1'b0);
    check("dw8_status", 32'(i8.data_out), 32'h01);
    beat8(2'b11, 8'h00, 3'd0, 1'b0);
    check("dw8_wrap", 32'(i8.data_out), 32'h10);
    @(negedge clk);
    check("dw8_valid_pulse", 32'(i8.out_valid), 32'd0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
